// File: rtl/arbitrated_fifo_bank_pkg.sv
// Shared constants and width helpers for the arbitrated FIFO bank.
// Contents:
//   DefNumFifos / DefWidth / DefDepth - default channel count, data width and depth.
//   tag_width()   - bits needed to name a channel.
//   count_width() - bits needed to hold an occupancy of 0..depth.
package arbitrated_fifo_pkg;

  localparam int unsigned DefNumFifos = 4;
  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefDepth    = 4;

  function automatic int unsigned tag_width(input int unsigned num_fifos);
    return (num_fifos > 1) ? $clog2(num_fifos) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arbitrated_fifo_bank_if.sv
// Handshake bundle for the arbitrated FIFO bank.
// Signals:
//   push/push_sel/push_data/push_ready  - per-channel write port
//   out_valid/out_ready/out_data/out_tag - merged read port
//   gnt/full/empty                       - per-channel status
// Modports: master (producer/consumer side), slave (bank side).
interface arbitrated_fifo_bank_if
  import arbitrated_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DefNumFifos,
  parameter int unsigned WIDTH     = DefWidth
);
  localparam int unsigned TAGWIDTH = tag_width(NUM_FIFOS);

  logic                 push;
  logic [TAGWIDTH-1:0]  push_sel;
  logic [WIDTH-1:0]     push_data;
  logic                 push_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [TAGWIDTH-1:0]  out_tag;
  logic [NUM_FIFOS-1:0] gnt;
  logic [NUM_FIFOS-1:0] full;
  logic [NUM_FIFOS-1:0] empty;

  modport master (
    output push, push_sel, push_data, out_ready,
    input  push_ready, out_valid, out_data, out_tag, gnt, full, empty
  );

  modport slave (
    input  push, push_sel, push_data, out_ready,
    output push_ready, out_valid, out_data, out_tag, gnt, full, empty
  );

endinterface

// File: rtl/arbitrated_fifo_bank_arbiter.sv
// Combinational one-hot arbiter for the FIFO bank.
// Ports: req (non-empty channels), ptr (round-robin start), lock / locked_gnt (held grant
// while the consumer stalls), gnt (one-hot result, zero when nothing requests).
// Build option RR_ARB_EN: defined -> round-robin search upward from ptr with wrap;
// undefined -> fixed priority, lowest requesting index wins and ptr is ignored.
module round_robin_arbiter
  import arbitrated_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DefNumFifos,
  parameter int unsigned TAGWIDTH  = tag_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [TAGWIDTH-1:0]  ptr,
  input  logic                 lock,
  input  logic [NUM_FIFOS-1:0] locked_gnt,
  output logic [NUM_FIFOS-1:0] gnt
);

  logic [NUM_FIFOS-1:0] pick;

`ifdef RR_ARB_EN
  // Winner is the requester with the smallest upward distance from ptr.
  always_comb begin
    int unsigned best;
    int unsigned dist;
    pick = '0;
    best = NUM_FIFOS;
    dist = 0;
    for (int unsigned c = 0; c < NUM_FIFOS; c++) begin
      dist = (c >= 32'(ptr)) ? c - 32'(ptr) : c + NUM_FIFOS - 32'(ptr);
      if (req[c] && (dist < best)) begin
        best    = dist;
        pick    = '0;
        pick[c] = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    found = 1'b0;
    pick  = '0;
    for (int unsigned c = 0; c < NUM_FIFOS; c++) begin
      if (req[c] && !found) begin
        pick[c] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`endif

  assign gnt = lock ? locked_gnt : pick;

endmodule

// File: rtl/arbitrated_fifo_bank.sv
// Bank of NUM_FIFOS circular FIFOs merged onto one valid/ready output.
// Ports: clk, rst_n (async, active-low), bus (arbitrated_fifo_bank_if.slave).
// Heads are shown ahead (no read latency); the grant is frozen while the consumer stalls so
// out_data/out_tag stay stable until accepted.
// Build option RR_ARB_EN: defined -> round-robin with rr_ptr; undefined -> fixed priority.
module arbitrated_fifo_bank
  import arbitrated_fifo_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DefNumFifos,
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth
) (
  input logic                   clk,
  input logic                   rst_n,
  arbitrated_fifo_bank_if.slave bus
);

  localparam int unsigned TAGWIDTH = tag_width(NUM_FIFOS);
  localparam int unsigned CntWidth = count_width(DEPTH);
  localparam int unsigned PtrWidth = $clog2(DEPTH);

  logic [NUM_FIFOS-1:0] full, empty, gnt;
  logic [NUM_FIFOS-1:0] locked_gnt_q, locked_gnt_d;
  logic                 lock_q, lock_d;
  logic [WIDTH-1:0]     head [NUM_FIFOS];
  logic [WIDTH-1:0]     out_data;
  logic [TAGWIDTH-1:0]  out_tag, arb_ptr;
  logic                 out_valid, pop, push_acc, sel_full, sel_in_range;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // push_ready looks only at the selected channel's full flag, never at a same-cycle pop.
  always_comb begin
    sel_full     = 1'b0;
    sel_in_range = 1'b0;
    for (int unsigned c = 0; c < NUM_FIFOS; c++) begin
      if (bus.push_sel == TAGWIDTH'(c)) begin
        sel_full     = full[c];
        sel_in_range = 1'b1;
      end
    end
  end

  assign bus.push_ready = !sel_full;
  assign push_acc       = bus.push && !sel_full && sel_in_range;
  assign out_valid      = ~&empty;
  assign pop            = out_valid && bus.out_ready;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fifo
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                wr_en, rd_en;

    assign wr_en = push_acc && (bus.push_sel == TAGWIDTH'(g));
    assign rd_en = pop && gnt[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        if (wr_en) begin
          mem_q[wr_ptr_q] <= bus.push_data;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        case ({wr_en, rd_en})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: ;
        endcase
      end
    end

    assign full[g]  = (cnt_q == CntWidth'(DEPTH));
    assign empty[g] = (cnt_q == '0);
    assign head[g]  = mem_q[rd_ptr_q];
  end

`ifdef RR_ARB_EN
  logic [TAGWIDTH-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pop) begin
      rr_ptr_d = (out_tag == TAGWIDTH'(NUM_FIFOS - 1)) ? '0 : out_tag + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign arb_ptr = rr_ptr_q;
`else
  assign arb_ptr = '0;
`endif

  round_robin_arbiter #(
    .NUM_FIFOS(NUM_FIFOS),
    .TAGWIDTH (TAGWIDTH)
  ) u_arb (
    .req       (~empty),
    .ptr       (arb_ptr),
    .lock      (lock_q),
    .locked_gnt(locked_gnt_q),
    .gnt       (gnt)
  );

  // A stalled head freezes the grant; acceptance releases it.
  always_comb begin
    lock_d       = lock_q;
    locked_gnt_d = locked_gnt_q;
    if (pop) begin
      lock_d = 1'b0;
    end else if (out_valid) begin
      lock_d       = 1'b1;
      locked_gnt_d = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      locked_gnt_q <= '0;
    end else begin
      lock_q       <= lock_d;
      locked_gnt_q <= locked_gnt_d;
    end
  end

  // AND-OR mux over the one-hot grant; yields zeros when nothing is granted.
  always_comb begin
    out_data = '0;
    out_tag  = '0;
    for (int unsigned c = 0; c < NUM_FIFOS; c++) begin
      out_data = out_data | ({WIDTH{gnt[c]}} & head[c]);
      out_tag  = out_tag | (gnt[c] ? TAGWIDTH'(c) : '0);
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_tag   = out_tag;
  assign bus.gnt       = gnt;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_arbitrated_fifo_bank.sv
// Directed bench for arbitrated_fifo_bank (NUM_FIFOS=4, WIDTH=8, DEPTH=4).
// Expected arbitration orders follow the RR_ARB_EN build option.
module tb_arbitrated_fifo_bank;

  localparam int unsigned NF = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  q [$];
  logic [7:0]  d;

  arbitrated_fifo_bank_if #(.NUM_FIFOS(NF), .WIDTH(W)) bus ();

  arbitrated_fifo_bank #(
    .NUM_FIFOS(NF),
    .WIDTH    (W),
    .DEPTH    (D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [1:0] sel, input logic [7:0] dat,
                       input logic rdy);
    bus.push      = p;
    bus.push_sel  = sel;
    bus.push_data = dat;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic idle_out(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, " gnt"},       32'(bus.gnt),       0);
    chk({tag, " out_tag"},   32'(bus.out_tag),   0);
    chk({tag, " out_data"},  32'(bus.out_data),  0);
  endtask

  task automatic exp_head(input string tag, input int unsigned ch, input logic [7:0] dat);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, " out_tag"},   32'(bus.out_tag),   ch);
    chk({tag, " out_data"},  32'(bus.out_data),  32'(dat));
    chk({tag, " gnt"},       32'(bus.gnt),       32'(1) << ch);
  endtask

  task automatic push_word(input logic [1:0] ch, input logic [7:0] dat);
    drive(1'b1, ch, dat, 1'b0);
    step();
  endtask

  task automatic pop_check(input string tag, input int unsigned ch, input logic [7:0] dat);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    exp_head(tag, ch, dat);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.push      = 1'b0;
    bus.push_sel  = '0;
    bus.push_data = '0;
    bus.out_ready = 1'b0;
    #2;
    idle_out("reset");
    chk("reset empty", 32'(bus.empty), 32'hF);
    chk("reset full", 32'(bus.full), 0);
    chk("reset push_ready", 32'(bus.push_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single push, one-cycle latency
    push_word(2'd1, 8'hA5);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    exp_head("s1 head", 1, 8'hA5);
    pop_check("s1 pop", 1, 8'hA5);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s1 drained");

    // 2: fill channel 2, overflow is dropped
    for (int i = 0; i < 4; i++) push_word(2'd2, 8'(8'h11 * (i + 1)));
    drive(1'b1, 2'd2, 8'h55, 1'b0);
    chk("s2 full", 32'(bus.full), 32'h4);
    chk("s2 push_ready", 32'(bus.push_ready), 0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("s2 still full", 32'(bus.full), 32'h4);
    for (int i = 0; i < 4; i++) pop_check("s2 drain", 2, 8'(8'h11 * (i + 1)));
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s2 drained");
    chk("s2 empty", 32'(bus.empty), 32'hF);

    // 3: one word per channel, then reloads
    for (int c = 0; c < 4; c++) push_word(2'(c), 8'(8'h10 + c));
    for (int c = 0; c < 4; c++) pop_check("s3 order", c, 8'(8'h10 + c));
    push_word(2'd0, 8'h20);
    push_word(2'd3, 8'h23);
    pop_check("s3 reload0", 0, 8'h20);
    pop_check("s3 reload3", 3, 8'h23);
    push_word(2'd0, 8'h31);
    push_word(2'd0, 8'h32);
    push_word(2'd3, 8'h33);
`ifdef RR_ARB_EN
    pop_check("s3 mix a", 0, 8'h31);
    pop_check("s3 mix b", 3, 8'h33);
    pop_check("s3 mix c", 0, 8'h32);
`else
    pop_check("s3 mix a", 0, 8'h31);
    pop_check("s3 mix b", 0, 8'h32);
    pop_check("s3 mix c", 3, 8'h33);
`endif
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s3 drained");

    // 4: stalled grant on channel 2 survives pushes elsewhere
    push_word(2'd2, 8'h2A);
    drive(1'b1, 2'd1, 8'h51, 1'b0);
    exp_head("s4 stall1", 2, 8'h2A);
    step();
    drive(1'b1, 2'd1, 8'h52, 1'b0);
    exp_head("s4 stall2", 2, 8'h2A);
    step();
    drive(1'b1, 2'd3, 8'h63, 1'b0);
    exp_head("s4 stall3", 2, 8'h2A);
    step();
    pop_check("s4 accept", 2, 8'h2A);
`ifdef RR_ARB_EN
    pop_check("s4 next a", 3, 8'h63);
    pop_check("s4 next b", 1, 8'h51);
    pop_check("s4 next c", 1, 8'h52);
`else
    pop_check("s4 next a", 1, 8'h51);
    pop_check("s4 next b", 1, 8'h52);
    pop_check("s4 next c", 3, 8'h63);
`endif
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s4 drained");

    // 5: push+pop on a full channel, then on a count-2 channel with wrap
    for (int i = 0; i < 4; i++) push_word(2'd0, 8'(8'h70 + i));
    drive(1'b1, 2'd0, 8'h74, 1'b1);
    chk("s5 full", 32'(bus.full), 32'h1);
    chk("s5 push_ready full", 32'(bus.push_ready), 0);
    exp_head("s5 pop full", 0, 8'h70);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("s5 not full", 32'(bus.full), 0);
    exp_head("s5 head", 0, 8'h71);
    q = '{8'h71, 8'h72, 8'h73};
    d = q.pop_front();
    pop_check("s5 pop one", 0, d);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, 8'(8'h80 + i), 1'b1);
      chk("s5 pp push_ready", 32'(bus.push_ready), 1);
      exp_head("s5 pp", 0, q[0]);
      step();
      d = q.pop_front();
      q.push_back(8'(8'h80 + i));
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("s5 pp empty", 32'(bus.empty), 32'hE);
    chk("s5 pp full", 32'(bus.full), 0);
    while (q.size() > 0) begin
      d = q.pop_front();
      pop_check("s5 drain", 0, d);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s5 drained");

    // 6: asynchronous reset between edges with traffic queued
    push_word(2'd0, 8'h90);
    push_word(2'd1, 8'h91);
    push_word(2'd2, 8'h92);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("s6 pre empty", 32'(bus.empty), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    idle_out("s6 rst");
    chk("s6 rst empty", 32'(bus.empty), 32'hF);
    chk("s6 rst full", 32'(bus.full), 0);
    chk("s6 rst push_ready", 32'(bus.push_ready), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    push_word(2'd1, 8'hA5);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    exp_head("s6 after", 1, 8'hA5);
    chk("s6 after empty", 32'(bus.empty), 32'hD);
    pop_check("s6 pop", 1, 8'hA5);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    idle_out("s6 drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitrated_fifo_bank.md
# arbitrated_fifo_bank

- Parametrised bank of `NUM_FIFOS` independent circular-pointer FIFOs whose heads are merged onto a single valid/ready output by an internal arbiter.
- Replaces the abstract, externally driven grant with a real grant. The grant is locked while the consumer stalls.
- Sits between per-channel producers and a single downstream consumer. The scoreboard taps `push`/`push_sel`/`push_data` and `out_*`.

## Interface
- `NUM_FIFOS`, 4: channel count, ≥2.
- `WIDTH`, 8: data width, ≥1.
- `DEPTH`, 4: entries per FIFO, ≥2; need not be a power of two.
- `TAGWIDTH`, `$clog2(NUM_FIFOS)`: channel index width; derived, never overridden.
- `clk  input  1`: single clock, rising edge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `push  input  1`: write request.
- `push_sel  input  TAGWIDTH`: target channel. Values ≥`NUM_FIFOS` are ignored.
- `push_data  input  WIDTH`: write data.
- `push_ready  output  1`: selected channel not full.
- `out_valid  output  1`: a head word is presented.
- `out_ready  input  1`: consumer accepts.
- `out_data  output  WIDTH`: granted head word; all zeros when `!out_valid`.
- `out_tag  output  TAGWIDTH`: granted channel index; zero when `!out_valid`.
- `gnt  output  NUM_FIFOS`: one-hot grant, zero when `!out_valid`.
- `full  output  NUM_FIFOS`: per-channel full.
- `empty  output  NUM_FIFOS`: per-channel empty.

## Operation
**Per-channel storage**
- Each channel holds `DEPTH` entries, a read pointer, a write pointer and a `$clog2(DEPTH+1)`-bit count.
- Pointers wrap from `DEPTH-1` to 0 explicitly, not by modulo-2^n.
- `full` is `count==DEPTH`; `empty` is `count==0`.
- The head word is shown ahead: `out_data` is storage at the read pointer, with no read latency.

**Push**
- A push is accepted when `push && push_ready && push_sel<NUM_FIFOS`.
- A push to a full channel is dropped and leaves no state change.
- `push_ready` does not depend on a same-cycle pop, so a full channel refuses a push even while it is being popped.

**Pop**
- A pop occurs when `out_valid && out_ready`, on the granted channel only.
- A push and a pop on the same channel in the same cycle leave the count unchanged and advance both pointers.

**Arbitration**
- Requests are `~empty`.
- The winner is the first non-empty channel found searching upward from `rr_ptr` with wrap.
- `out_valid = |~empty`.

**Grant lock**
- Set when `out_valid && !out_ready`. While set, the locked grant is held and `gnt`, `out_tag` and `out_data` are frozen.
- A new push to another channel never changes the locked grant.
- Cleared on acceptance.

**Pointer update**
- On acceptance, `rr_ptr` becomes `out_tag+1`, wrapping at `NUM_FIFOS`.
- Otherwise `rr_ptr` holds.

## Timing
**Reset values** (all state cleared asynchronously on `rst_n` low):
- All counts, pointers, `rr_ptr` and the lock are 0.
- `out_valid=0`, `gnt=0`, `out_tag=0`, `out_data=0`.
- `empty` all ones, `full=0`, `push_ready=1`.

**Reset mid-operation**
- All queued data is discarded.
- Outputs return to reset values in the same cycle `rst_n` falls.
- No pop is counted for that cycle.

**Latency**
- A word pushed into an empty bank at edge t gives `out_valid=1` after edge t. This is a 1-cycle push-to-valid latency.
- Back-to-back acceptance is supported: one word per cycle, with no bubble when a single channel has ≥2 entries.

**Handshake**
- Once asserted, `out_valid`, `out_data` and `out_tag` stay stable until accepted. The lock guarantees this.

**Combinational paths**
- `push_ready` is combinational from `push_sel`.
- `out_data`, `out_tag` and `gnt` are combinational from state.
- No path runs from `out_ready` to `out_valid`.

## Configuration
- `RR_ARB_EN` defined: round-robin arbitration as described above.
- `RR_ARB_EN` undefined: fixed priority, lowest non-empty index wins.
  - `rr_ptr` is removed; the grant lock is still present.
  - Starvation of high indices is permitted.

## Structure
- Package `arbitrated_fifo_pkg`: the `TAGWIDTH`/count-width helper function and default constants for `NUM_FIFOS`, `WIDTH` and `DEPTH`.
- Sub-module `round_robin_arbiter`:
  - Inputs: `req`, `ptr`, `lock`, `locked_gnt`.
  - Output: one-hot `gnt`.
  - Purely combinational.
  - Owns the `RR_ARB_EN` switch.
- FIFO storage is a generate loop inside the top module, with no further sub-modules.
- The output mux is an AND-OR over the one-hot `gnt`.

## Test plan
1. **Reset, then a single push.** Reset, then push 0xA5 to channel 1.
   - Next cycle: `out_valid=1`, `out_tag=1`, `out_data=0xA5`, `gnt=4'b0010`.
2. **Fill and overflow.** Push 5 words to channel 2 with `DEPTH=4` and `out_ready=0`.
   - `full[2]=1` after the 4th push, and the 5th is dropped.
   - Draining yields exactly the 4 words, in order.
3. **Round-robin order.** Load one word into each of channels 0–3 and hold `out_ready=1`.
   - Grants run 0,1,2,3.
   - Reloading channels 0 and 3 then gives grant 0, then 3.
   - With `RR_ARB_EN` off, two words in ch0 and one in ch3 give order 0,0,3.
4. **Stall lock.** Channel 2 is granted with `out_ready=0` for 3 cycles while channel 1 is pushed.
   - `gnt`/`out_tag`/`out_data` stay at channel 2 for all 3 cycles.
   - After acceptance the grant moves to channel 3 if it is non-empty, else wraps to channel 1.
5. **Simultaneous push and pop.** On a full channel 0 that is granted, apply push and `out_ready=1`.
   - The push is refused and the count drops to 3.
   - On a count-2 channel the same stimulus leaves the count at 2.
   - Pointers wrap correctly after 10 such cycles.
6. **Asynchronous reset mid-traffic.** Pull `rst_n` low between clock edges while 3 channels hold data.
   - `out_valid=0` and `empty=4'b1111` immediately.
   - After release, the first push behaves as in scenario 1.
